harmonic_mix_sequencer: RTL and testbench

//  Initiator for the scaled-sample adder. On each output-sample tick, clears the adder's accumulator.
//  It then walks harmonics 0..HARMONICS-1; for each one it fetches the sine sample and level, and drives one

---
 rtl/harmonic_mix_sequencer_pkg.sv | 34 +++
 rtl/harmonic_mix_sequencer_sat_shift16.sv | 20 ++
 rtl/harmonic_mix_sequencer.sv | 168 ++++++++++++++++
 tb/tb_harmonic_mix_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harmonic_mix_sequencer_pkg.sv
// Shared widths, state encoding and saturation helper for the harmonic mix sequencer.
package harmonic_mix_sequencer_pkg;

  localparam int unsigned SAMPLE_W     = 16;
  localparam int unsigned ACC_W        = 32;
  // Level is a fraction of 2^DIVISOR_BITS; the adder divides each product by this.
  localparam int unsigned DIVISOR_BITS = 9;

  localparam logic signed [ACC_W-1:0] SatMax = 32'sd32767;
  localparam logic signed [ACC_W-1:0] SatMin = -32'sd32768;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StFetch  = 3'd2,
    StStart  = 3'd3,
    StWait   = 3'd4,
    StOutput = 3'd5
  } state_e;

  // Clamp a full-width value into the signed 16-bit sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] value);
    logic signed [SAMPLE_W-1:0] result;
    if (value > SatMax) begin
      result = 16'sh7fff;
    end else if (value < SatMin) begin
      result = 16'sh8000;
    end else begin
      result = value[SAMPLE_W-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/harmonic_mix_sequencer_sat_shift16.sv
// Arithmetic right shift of the accumulator followed by 16-bit saturation.
// Purely combinational; also used on the output filter path.
module harmonic_mix_sequencer_sat_shift16
  import harmonic_mix_sequencer_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = 4
) (
  input  logic signed [ACC_W-1:0]    acc_i,
  output logic signed [SAMPLE_W-1:0] sat_o
);

  logic signed [ACC_W-1:0] shifted;

  // Shift keeps the sign, then clamp into range.
  always_comb begin
    shifted = acc_i >>> OUT_SHIFT;
    sat_o   = sat16(shifted);
  end

endmodule

// File: rtl/harmonic_mix_sequencer.sv
// Harmonic mix sequencer: per output tick, clears the scaled-sample adder, walks every
// harmonic through lookup and one multiply-accumulate, then emits a saturated mix sample.
module harmonic_mix_sequencer
  import harmonic_mix_sequencer_pkg::*;
#(
  parameter int unsigned HARMONICS = 32,
  parameter int unsigned HARM_BITS = 5,
  parameter int unsigned OUT_SHIFT = 4
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Sample_Tick,
  output logic [HARM_BITS-1:0]       o_Harmonic,
  output logic                       o_Lookup_Req,
  input  logic                       i_Lookup_Valid,
  input  logic signed [SAMPLE_W-1:0] i_Sample,
  input  logic signed [SAMPLE_W-1:0] i_Level,
  output logic                       o_Add_Clear,
  output logic                       o_Add_Start,
  output logic signed [SAMPLE_W-1:0] o_Add_Multiple,
  output logic signed [SAMPLE_W-1:0] o_Add_Sample,
  input  logic                       i_Add_Done,
  input  logic signed [ACC_W-1:0]    i_Accumulator,
  output logic signed [SAMPLE_W-1:0] o_Mix,
  output logic                       o_Mix_Valid,
  output logic                       o_Busy,
  output logic                       o_Overrun
);

  localparam logic [HARM_BITS-1:0] LastHarm = HARM_BITS'(HARMONICS - 1);
  localparam logic [HARM_BITS-1:0] HarmOne  = HARM_BITS'(1);

  state_e                      state_q, state_d;
  logic [HARM_BITS-1:0]        harm_q, harm_d;
  // Marks the first cycle of FETCH (request cycle) and of WAIT (guard cycle).
  logic                        first_q, first_d;
  logic signed [SAMPLE_W-1:0]  mult_q, mult_d;
  logic signed [SAMPLE_W-1:0]  samp_q, samp_d;
  logic signed [SAMPLE_W-1:0]  mix_q, mix_d;
  logic                        mix_valid_q, mix_valid_d;
  logic                        busy_q, busy_d;
  logic                        overrun_q, overrun_d;
  logic                        advance;
  logic signed [SAMPLE_W-1:0]  sat_mix;

  harmonic_mix_sequencer_sat_shift16 #(
    .OUT_SHIFT (OUT_SHIFT)
  ) u_sat_shift16 (
    .acc_i (i_Accumulator),
    .sat_o (sat_mix)
  );

  // Next-state logic: sequencing, operand capture and mix update.
  always_comb begin
    state_d     = state_q;
    harm_d      = harm_q;
    first_d     = 1'b0;
    mult_d      = mult_q;
    samp_d      = samp_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    advance     = 1'b0;

    // Ticks are only honoured in IDLE; anything else is a dropped request.
    if (i_Sample_Tick && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_Sample_Tick) begin
          state_d = StClear;
          busy_d  = 1'b1;
          harm_d  = '0;
        end
      end
      StClear: begin
        state_d = StFetch;
        first_d = 1'b1;
      end
      StFetch: begin
        // Valid is not trusted in the request cycle itself.
        if (!first_q && i_Lookup_Valid) begin
          mult_d = i_Level;
          samp_d = i_Sample;
          if (i_Level == '0) begin
            advance = 1'b1;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        state_d = StWait;
        first_d = 1'b1;
      end
      StWait: begin
        // Done is still stale from the previous transaction in the guard cycle.
        if (!first_q && i_Add_Done) begin
          advance = 1'b1;
        end
      end
      StOutput: begin
        mix_d       = sat_mix;
        mix_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Shared move to the next harmonic or to the output stage; never wraps.
    if (advance) begin
      if (harm_q == LastHarm) begin
        state_d = StOutput;
      end else begin
        harm_d  = harm_q + HarmOne;
        state_d = StFetch;
        first_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= StIdle;
      harm_q      <= '0;
      first_q     <= 1'b0;
      mult_q      <= '0;
      samp_q      <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      harm_q      <= harm_d;
      first_q     <= first_d;
      mult_q      <= mult_d;
      samp_q      <= samp_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // Strobes decode from state; reset forces clear high and masks the rest.
  always_comb begin
    o_Add_Clear  = i_Reset || (state_q == StClear);
    o_Add_Start  = !i_Reset && (state_q == StStart);
    o_Lookup_Req = !i_Reset && (state_q == StFetch) && first_q;
  end

  assign o_Harmonic     = harm_q;
  assign o_Add_Multiple = mult_q;
  assign o_Add_Sample   = samp_q;
  assign o_Mix          = mix_q;
  assign o_Mix_Valid    = mix_valid_q;
  assign o_Busy         = busy_q;
  assign o_Overrun      = overrun_q;

endmodule

// File: tb/tb_harmonic_mix_sequencer.sv
// Bench for harmonic_mix_sequencer: two instances (4 harmonics/no shift, 32 harmonics/shift 4),
// each with an adder responder and a lookup model with programmable latency.
module tb_harmonic_mix_sequencer;
  import harmonic_mix_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic mrst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [15:0] exp_q[$];

  // ---------------- instance A: HARMONICS=4, OUT_SHIFT=0 ----------------
  logic              tick_a, req_a, lv_a, clr_a, start_a, done_a, mixv_a, busy_a, ovr_a;
  logic [1:0]        harm_a;
  logic signed [15:0] samp_a, lvl_a, mult_a, asamp_a, mix_a;
  logic signed [31:0] acc_a, prod_a;
  logic signed [15:0] lvl_tab_a [4];
  logic signed [15:0] samp_tab_a [4];
  int lat_a, cnt_a, starts_a, valids_a, glitch_a;
  logic pend_a;
  logic signed [15:0] om_a, os_a;

  assign lvl_a  = lvl_tab_a[harm_a];
  assign samp_a = samp_tab_a[harm_a];
  assign prod_a = mult_a * asamp_a;

  harmonic_mix_sequencer #(
    .HARMONICS (4),
    .HARM_BITS (2),
    .OUT_SHIFT (0)
  ) dut_a (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Sample_Tick  (tick_a),
    .o_Harmonic     (harm_a),
    .o_Lookup_Req   (req_a),
    .i_Lookup_Valid (lv_a),
    .i_Sample       (samp_a),
    .i_Level        (lvl_a),
    .o_Add_Clear    (clr_a),
    .o_Add_Start    (start_a),
    .o_Add_Multiple (mult_a),
    .o_Add_Sample   (asamp_a),
    .i_Add_Done     (done_a),
    .i_Accumulator  (acc_a),
    .o_Mix          (mix_a),
    .o_Mix_Valid    (mixv_a),
    .o_Busy         (busy_a),
    .o_Overrun      (ovr_a)
  );

  // Lookup model A: valid one pulse, lat_a cycles after the request cycle.
  always @(posedge clk) begin
    if (mrst) begin
      cnt_a <= 0;
      lv_a  <= 1'b0;
    end else if (req_a) begin
      cnt_a <= lat_a - 1;
      lv_a  <= (lat_a == 1);
    end else if (cnt_a != 0) begin
      cnt_a <= cnt_a - 1;
      lv_a  <= (cnt_a == 1);
    end else begin
      lv_a  <= 1'b0;
    end
  end

  // Adder model A: done drops after start, result one cycle later; flags operand changes.
  always @(posedge clk) begin
    if (mrst) begin
      done_a <= 1'b1; pend_a <= 1'b0; acc_a <= '0; starts_a <= 0; glitch_a <= 0;
      om_a <= '0; os_a <= '0;
    end else begin
      if (clr_a) acc_a <= '0;
      else if (pend_a) acc_a <= acc_a + (prod_a >>> DIVISOR_BITS);
      if (start_a) begin
        done_a <= 1'b0; pend_a <= 1'b1; om_a <= mult_a; os_a <= asamp_a;
        starts_a <= starts_a + 1;
      end else if (pend_a) begin
        done_a <= 1'b1; pend_a <= 1'b0;
        if (mult_a !== om_a || asamp_a !== os_a) glitch_a <= glitch_a + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (mrst) valids_a <= 0;
    else if (mixv_a) valids_a <= valids_a + 1;
  end

  // ---------------- instance B: HARMONICS=32, OUT_SHIFT=4 ----------------
  logic              tick_b, req_b, lv_b, clr_b, start_b, done_b, mixv_b, busy_b, ovr_b;
  logic [4:0]        harm_b;
  logic signed [15:0] samp_b, lvl_b, mult_b, asamp_b, mix_b;
  logic signed [31:0] acc_b, prod_b;
  int cnt_b, starts_b, valids_b;
  logic pend_b;

  assign prod_b = mult_b * asamp_b;

  harmonic_mix_sequencer #(
    .HARMONICS (32),
    .HARM_BITS (5),
    .OUT_SHIFT (4)
  ) dut_b (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Sample_Tick  (tick_b),
    .o_Harmonic     (harm_b),
    .o_Lookup_Req   (req_b),
    .i_Lookup_Valid (lv_b),
    .i_Sample       (samp_b),
    .i_Level        (lvl_b),
    .o_Add_Clear    (clr_b),
    .o_Add_Start    (start_b),
    .o_Add_Multiple (mult_b),
    .o_Add_Sample   (asamp_b),
    .i_Add_Done     (done_b),
    .i_Accumulator  (acc_b),
    .o_Mix          (mix_b),
    .o_Mix_Valid    (mixv_b),
    .o_Busy         (busy_b),
    .o_Overrun      (ovr_b)
  );

  // Lookup model B: fixed one-cycle latency.
  always @(posedge clk) begin
    if (mrst) begin
      cnt_b <= 0;
      lv_b  <= 1'b0;
    end else begin
      lv_b <= req_b;
    end
  end

  // Adder model B.
  always @(posedge clk) begin
    if (mrst) begin
      done_b <= 1'b1; pend_b <= 1'b0; acc_b <= '0; starts_b <= 0;
    end else begin
      if (clr_b) acc_b <= '0;
      else if (pend_b) acc_b <= acc_b + (prod_b >>> DIVISOR_BITS);
      if (start_b) begin
        done_b <= 1'b0; pend_b <= 1'b1; starts_b <= starts_b + 1;
      end else if (pend_b) begin
        done_b <= 1'b1; pend_b <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (mrst) valids_b <= 0;
    else if (mixv_b) valids_b <= valids_b + 1;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tab_a(input logic signed [15:0] l0, input logic signed [15:0] l1,
                           input logic signed [15:0] l2, input logic signed [15:0] l3,
                           input logic signed [15:0] s);
    lvl_tab_a[0] = l0; lvl_tab_a[1] = l1; lvl_tab_a[2] = l2; lvl_tab_a[3] = l3;
    for (int i = 0; i < 4; i++) samp_tab_a[i] = s;
  endtask

  // One full sequence on A: expected mix queued at tick, popped at mix valid.
  task automatic run_a(input string tag, input int exp_lat, input logic [15:0] exp_mix,
                       input int exp_starts);
    int n;
    int s0;
    int v0;
    logic [15:0] e;
    s0 = starts_a;
    v0 = valids_a;
    exp_q.push_back(exp_mix);
    @(negedge clk); tick_a = 1'b1;
    @(posedge clk); #1 tick_a = 1'b0;
    n = 0;
    while (!mixv_a && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    if (mixv_a && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, " mix"}, {16'h0, mix_a}, {16'h0, e});
    end
    repeat (5) @(negedge clk);
    check({tag, " starts"}, starts_a - s0, exp_starts);
    check({tag, " valids"}, valids_a - v0, 1);
    check({tag, " busy idle"}, {31'h0, busy_a}, 0);
  endtask

  // One full sequence on B, with an optional second tick second_at cycles later.
  task automatic run_b(input string tag, input logic [15:0] exp_mix, input int second_at);
    int n;
    int v0;
    logic [15:0] e;
    v0 = valids_b;
    exp_q.push_back(exp_mix);
    @(negedge clk); tick_b = 1'b1;
    @(posedge clk); #1 tick_b = 1'b0;
    n = 0;
    while (!mixv_b && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (second_at != 0 && n == second_at) begin
        tick_b = 1'b1;
        @(posedge clk); #1 tick_b = 1'b0;
        n++;
      end
    end
    check({tag, " latency"}, n, 162);
    if (mixv_b && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, " mix"}, {16'h0, mix_b}, {16'h0, e});
    end
    repeat (10) @(negedge clk);
    check({tag, " valids"}, valids_b - v0, 1);
    check({tag, " overrun"}, {31'h0, ovr_b}, (second_at != 0) ? 1 : 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int v0;
    rst = 1'b1; mrst = 1'b1;
    tick_a = 1'b0; tick_b = 1'b0;
    lat_a = 1;
    lvl_b = 16'sd256; samp_b = 16'sd1000;
    set_tab_a(16'sd256, 16'sd256, 16'sd256, 16'sd256, 16'sd1000);
    repeat (3) @(posedge clk);
    @(negedge clk); mrst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst clear", {31'h0, clr_a}, 1);
    check("rst busy", {31'h0, busy_a}, 0);
    check("rst harm", {30'h0, harm_a}, 0);
    check("rst req", {31'h0, req_a}, 0);
    check("rst start", {31'h0, start_a}, 0);
    check("rst mult", {16'h0, mult_a}, 0);
    check("rst mix", {16'h0, mix_a}, 0);
    check("rst mixv", {31'h0, mixv_a}, 0);
    check("rst ovr", {31'h0, ovr_a}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("clear after rst", {31'h0, clr_a}, 0);

    // 4 x (256*1000/512) = 2000
    run_a("case1", 22, 16'd2000, 4);

    // Zero levels skip the adder: 2 x 500, three cycles saved each
    set_tab_a(16'sd256, 16'sd0, 16'sd256, 16'sd0, 16'sd1000);
    run_a("case3", 16, 16'd1000, 2);

    // Slow lookup: starts wait for valid, operands held
    set_tab_a(16'sd256, 16'sd256, 16'sd256, 16'sd256, 16'sd1000);
    lat_a = 4;
    run_a("case6", 34, 16'd2000, 4);
    check("case6 operand stable", glitch_a, 0);
    lat_a = 1;

    // Reset mid-sequence, then a fresh run must match case 1
    v0 = valids_a;
    @(negedge clk); tick_a = 1'b1;
    @(negedge clk); tick_a = 1'b0;
    n = 0;
    while (harm_a != 2'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("case5 reached harm2", {30'h0, harm_a}, 2);
    rst = 1'b1;
    @(negedge clk);
    check("case5 clear in rst", {31'h0, clr_a}, 1);
    check("case5 busy in rst", {31'h0, busy_a}, 0);
    check("case5 harm in rst", {30'h0, harm_a}, 0);
    check("case5 mix in rst", {16'h0, mix_a}, 0);
    @(negedge clk); rst = 1'b0;
    repeat (30) @(negedge clk);
    check("case5 no valid", valids_a - v0, 0);
    run_a("case5 rerun", 22, 16'd2000, 4);
    check("overrun A", {31'h0, ovr_a}, 0);

    // Saturation on B: 32 x 32703 >>> 4 and 32 x -32704 >>> 4
    lvl_b = 16'sd511; samp_b = 16'sd32767;
    run_b("case2 pos", 16'h7fff, 0);
    samp_b = -16'sd32768;
    run_b("case2 neg", 16'h8000, 0);

    // Tick while busy is dropped: 32 x 500 >>> 4 = 1000
    lvl_b = 16'sd256; samp_b = 16'sd1000;
    run_b("case4", 16'd1000, 50);
    check("scoreboard empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
